alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing the datapath (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning the datapath result width.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of EXEC cycles allowed before dp_done.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_opcode  input  NUM_REQ x 4  per-requester opcode.
REQ-008 req_a, req_b  input  NUM_REQ x 8 each  per-requester operands.
REQ-009 req_ready  output  NUM_REQ  one-hot grant; a handshake occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 rsp_valid  output  NUM_REQ  one-hot response strobe.
REQ-011 rsp_result  output  WIDTH  result shared by all requesters, qualified by rsp_valid.
REQ-012 rsp_error  output  1  error flag, qualified by rsp_valid.
REQ-013 dp_enable, dp_opcode[3:0], dp_a[7:0], dp_b[7:0]  output  datapath command.
REQ-014 dp_done  input  1; dp_result  input  WIDTH  datapath completion and result.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC, RESPOND.
REQ-016 In IDLE with any req_valid high, the block SHALL select a winner round-robin, searching from last_grant+1 with wrap-around modulo NUM_REQ, and assert req_ready[winner] combinationally in that cycle only.
REQ-017 On the handshake, the block SHALL latch the winner index, opcode, a and b.
REQ-018 Opcodes 0..3 SHALL be valid; any opcode 4..15 SHALL cause a transition from IDLE to RESPOND with rsp_error=1 and rsp_result=0, and the datapath SHALL NOT be enabled.
REQ-019 A valid opcode SHALL cause a transition from IDLE to EXEC.
REQ-020 In EXEC, dp_enable SHALL be 1 and dp_opcode/dp_a/dp_b SHALL equal the latched values, held stable for the whole of EXEC.
REQ-021 In EXEC, when dp_done=1, the block SHALL latch dp_result and go to RESPOND with rsp_error=0.
REQ-022 An EXEC cycle counter SHALL start at 0 on entry; if dp_done is still 0 in the cycle where the counter equals TIMEOUT-1, the block SHALL go to RESPOND with rsp_error=1 and rsp_result=0.
REQ-023 dp_done=1 in that same final cycle SHALL take priority over the timeout.
REQ-024 In RESPOND, rsp_valid[winner] SHALL be high for exactly one cycle, last_grant SHALL be updated to the winner, and the next state SHALL be IDLE.
REQ-025 req_ready SHALL be all-zero outside IDLE; requests arriving in EXEC or RESPOND SHALL wait and SHALL NOT be dropped.
REQ-026 dp_done outside EXEC SHALL be ignored.
REQ-027 A requester deasserting req_valid before it is granted SHALL NOT be granted.
REQ-028 Minimum turnaround SHALL be 3 cycles per operation (IDLE, EXEC, RESPOND).
REQ-029 The next grant MAY occur in the cycle after RESPOND.
REQ-030 dp_opcode, dp_a and dp_b SHALL be 0 whenever dp_enable is 0.

Reset
REQ-031 On reset the block SHALL enter IDLE and set last_grant=NUM_REQ-1, so that requester 0 has first priority.
REQ-032 On reset the following SHALL be cleared: the counter, the latched fields, and all outputs (req_ready, rsp_valid, rsp_result, rsp_error, dp_enable, dp_opcode, dp_a, dp_b).
REQ-033 Reset during EXEC or RESPOND SHALL abort the operation with no response issued.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/EXEC/RESPOND), the opcode constants (ADD=0, SUB=1, AND=2, OR=3, HALT=15) and the MAX_VALID_OPCODE=3 constant.
REQ-035 The round-robin winner selection SHALL be a sub-module, rr_picker: combinational; inputs req and last_grant; outputs grant (one-hot) and a valid flag.

Verification
REQ-036 Single op: req_valid[2]=1, opcode 0, a=5, b=7; dp_done 2 cycles later with dp_result=12 -> req_ready[2] for 1 cycle, dp_enable for 2 cycles, rsp_valid[2] pulse with rsp_result=12 and rsp_error=0.
REQ-037 Fairness: all 4 requesters held valid from reset -> grant order 0,1,2,3,0.
REQ-038 Fairness with a missing requester: requester 1 drops out after the first round -> grant order continues 2,3,0,2.
REQ-039 Invalid opcode: opcode 4'hF from requester 1 -> rsp_valid[1] one cycle after grant, rsp_error=1, rsp_result=0, dp_enable never asserted.
REQ-040 Timeout: TIMEOUT=8 and dp_done held low -> exactly 8 dp_enable cycles, then rsp_error=1.
REQ-041 Timeout boundary: dp_done=1 on the 8th cycle -> rsp_error=0 and the result is passed through.
REQ-042 Reset mid-EXEC: reset asserted on the 2nd EXEC cycle -> no rsp_valid, all outputs 0 the next cycle, requester 0 granted first afterwards.
REQ-043 Spurious and late events: dp_done pulsed in IDLE is ignored; a request raised during EXEC is granted in the IDLE cycle following RESPOND.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, opcodes and
// the latched datapath command.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] MAX_VALID_OPCODE = OP_OR;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } dp_cmd_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op <= MAX_VALID_OPCODE);
  endfunction

endpackage

// File: rtl/alu_arbiter_picker.sv
// Combinational round-robin picker: first requester found searching upward
// from last_grant+1, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  int w_idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = 0;
    // offset NUM_REQ wraps back to last_grant itself, so it has lowest priority
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = (int'(last_grant) + off) % NUM_REQ;
      if (!valid && req[IDX_W'(w_idx)]) begin
        grant[IDX_W'(w_idx)] = 1'b1;
        valid                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared multi-cycle ALU datapath:
// IDLE grants round-robin, EXEC drives the datapath, RESPOND returns the result.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*4-1:0]   req_opcode,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_error,
  output logic                   dp_enable,
  output logic [3:0]             dp_opcode,
  output logic [7:0]             dp_a,
  output logic [7:0]             dp_b,
  input  logic                   dp_done,
  input  logic [WIDTH-1:0]       dp_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_winner;
  logic [IDX_W-1:0]   w_win_idx;
  dp_cmd_t            r_cmd;
  dp_cmd_t            w_sel_cmd;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_error;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_vld;
  logic               w_timeout;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .valid      (w_grant_vld)
  );

  assign w_timeout = (r_cnt == CNT_LAST);

  // Steer the winning requester's command out of the flattened request buses
  always_comb begin
    w_sel_cmd = '0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_cmd.opcode = req_opcode[i*4 +: 4];
        w_sel_cmd.a      = req_a[i*8 +: 8];
        w_sel_cmd.b      = req_b[i*8 +: 8];
        w_win_idx        = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_next = op_is_valid(w_sel_cmd.opcode) ? EXEC : RESPOND;
        end
      end
      EXEC: begin
        if (dp_done || w_timeout) begin
          w_next = RESPOND;
        end
      end
      RESPOND: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_INIT;
      r_winner     <= '0;
      r_cmd        <= '0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_winner <= w_win_idx;
            r_cmd    <= w_sel_cmd;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= !op_is_valid(w_sel_cmd.opcode);
          end
        end
        EXEC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // a completion in the last allowed cycle still wins over the timeout
          if (dp_done) begin
            r_result <= dp_result;
            r_error  <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_error  <= 1'b1;
          end
        end
        RESPOND: r_last_grant <= r_winner;
        default: ;
      endcase
    end
  end

  // Outputs decode from state; held at zero while reset is asserted
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_error  = 1'b0;
    dp_enable  = 1'b0;
    dp_opcode  = '0;
    dp_a       = '0;
    dp_b       = '0;
    if (!reset) begin
      case (r_state)
        IDLE: req_ready = w_grant;
        EXEC: begin
          dp_enable = 1'b1;
          dp_opcode = r_cmd.opcode;
          dp_a      = r_cmd.a;
          dp_b      = r_cmd.b;
        end
        RESPOND: begin
          rsp_valid  = NUM_REQ'(1) << r_winner;
          rsp_result = r_result;
          rsp_error  = r_error;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors push expected grants and
// responses; independent monitors pop and compare as the DUT presents them.
module tb_alu_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*4-1:0] req_opcode;
  logic [NR*8-1:0] req_a;
  logic [NR*8-1:0] req_b;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [W-1:0]    rsp_result;
  logic            rsp_error;
  logic            dp_enable;
  logic [3:0]      dp_opcode;
  logic [7:0]      dp_a;
  logic [7:0]      dp_b;
  logic            dp_done = 1'b0;
  logic [W-1:0]    dp_result = '0;

  alu_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .dp_enable  (dp_enable),
    .dp_opcode  (dp_opcode),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_done    (dp_done),
    .dp_result  (dp_result)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int gap; } gexp_t;
  typedef struct { int idx; logic [W-1:0] res; logic err; int lat; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_grants = 0;
  int n_rsps = 0;
  int last_gcyc = 0;
  int dp_en_total = 0;
  int dp_lat = 0;
  logic [W-1:0] dp_res_val = '0;
  logic force_done = 1'b0;
  logic [3:0] g_op = '0;
  logic [7:0] g_a = '0;
  logic [7:0] g_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_g(input int idx, input int gap);
    gexp_t g;
    g.idx = idx; g.gap = gap;
    gq.push_back(g);
  endtask

  task automatic push_r(input int idx, input logic [W-1:0] res, input logic err, input int lat);
    rexp_t r;
    r.idx = idx; r.res = res; r.err = err; r.lat = lat;
    rq.push_back(r);
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    req_opcode[i*4 +: 4] = op;
    req_a[i*8 +: 8]      = a;
    req_b[i*8 +: 8]      = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input int budget);
    for (int k = 0; k < budget && n_grants < target; k++) step();
    chk("wait_grants", 32'(n_grants >= target), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && (gq.size() != 0 || rq.size() != 0); k++) step();
    chk("drain", 32'(gq.size() + rq.size()), 32'd0);
    step();
    step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Grant monitor
  initial begin
    int gi;
    gexp_t g;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dp_enable || rsp_valid != '0) chk("ready_outside_idle", 32'(req_ready), 32'd0);
        if (req_ready != '0) begin
          gi = -1;
          for (int i = 0; i < NR; i++) if (req_ready[i]) gi = i;
          chk("grant_onehot", 32'($countones(req_ready)), 32'd1);
          chk("grant_needs_valid", 32'((req_ready & req_valid) != '0), 32'd1);
          if (gq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL grant_unexpected: got req_ready %b, expected none", req_ready);
          end else begin
            g = gq.pop_front();
            chk("grant_idx", 32'(gi), 32'(g.idx));
            if (g.gap >= 0) chk("grant_gap", 32'(cyc - last_gcyc), 32'(g.gap));
          end
          g_op = req_opcode[gi*4 +: 4];
          g_a  = req_a[gi*8 +: 8];
          g_b  = req_b[gi*8 +: 8];
          last_gcyc = cyc;
          n_grants++;
        end
      end
    end
  end

  // Response monitor
  initial begin
    int ri;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        ri = -1;
        for (int i = 0; i < NR; i++) if (rsp_valid[i]) ri = i;
        chk("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rsp_unexpected: got rsp_valid %b, expected none", rsp_valid);
        end else begin
          r = rq.pop_front();
          chk("rsp_idx", 32'(ri), 32'(r.idx));
          chk("rsp_result", 32'(rsp_result), 32'(r.res));
          chk("rsp_error", 32'(rsp_error), 32'(r.err));
          if (r.lat >= 0) chk("rsp_latency", 32'(cyc - last_gcyc), 32'(r.lat));
        end
        n_rsps++;
      end
    end
  end

  // Datapath model: finishes on its dp_lat-th enabled cycle (0 = never)
  initial begin
    int ecnt;
    ecnt = 0;
    forever begin
      @(negedge clk);
      if (dp_enable) begin
        dp_en_total++;
        ecnt++;
        chk("dp_opcode", 32'(dp_opcode), 32'(g_op));
        chk("dp_a", 32'(dp_a), 32'(g_a));
        chk("dp_b", 32'(dp_b), 32'(g_b));
        dp_done   = force_done || (dp_lat != 0 && ecnt == dp_lat);
        dp_result = dp_res_val;
      end else begin
        ecnt = 0;
        chk("dp_idle_zero", 32'({dp_opcode, dp_a, dp_b}), 32'd0);
        dp_done   = force_done;
        dp_result = force_done ? 16'hDEAD : '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int base;
    int r0;
    reset      = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    repeat (3) step();
    reset = 1'b0;

    // Outputs idle after reset
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_result, rsp_error}), 32'd0);
    chk("rst_dp", 32'({dp_enable, dp_opcode, dp_a, dp_b}), 32'd0);
    step();

    // Single ADD op: 5 + 7 = 12, done on 2nd EXEC cycle
    set_req(2, 4'd0, 8'd5, 8'd7);
    dp_lat = 2; dp_res_val = 16'd12;
    push_g(2, -1); push_r(2, 16'd12, 1'b0, 3);
    e0 = dp_en_total;
    req_valid = 4'b0100;
    wait_grants(n_grants + 1, 20);
    req_valid = '0;
    wait_drain(40);
    chk("single_dp_cycles", 32'(dp_en_total - e0), 32'd2);

    // Fairness from reset: 0,1,2,3,0 with 3-cycle turnaround
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 4'd0, 8'(i + 1), 8'(8'h10 + i));
    dp_lat = 1; dp_res_val = 16'h00C3;
    push_g(0, -1); push_g(1, 3); push_g(2, 3); push_g(3, 3); push_g(0, 3);
    push_r(0, 16'h00C3, 1'b0, 2); push_r(1, 16'h00C3, 1'b0, 2);
    push_r(2, 16'h00C3, 1'b0, 2); push_r(3, 16'h00C3, 1'b0, 2);
    push_r(0, 16'h00C3, 1'b0, 2);
    base = n_grants;
    req_valid = 4'b1111;
    wait_grants(base + 5, 60);
    req_valid = '0;
    wait_drain(40);

    // Requester 1 drops after its grant: continues 2,3,0,2
    do_reset();
    push_g(0, -1); push_g(1, 3); push_g(2, 3); push_g(3, 3); push_g(0, 3); push_g(2, 3);
    push_r(0, 16'h00C3, 1'b0, 2); push_r(1, 16'h00C3, 1'b0, 2);
    push_r(2, 16'h00C3, 1'b0, 2); push_r(3, 16'h00C3, 1'b0, 2);
    push_r(0, 16'h00C3, 1'b0, 2); push_r(2, 16'h00C3, 1'b0, 2);
    base = n_grants;
    req_valid = 4'b1111;
    wait_grants(base + 2, 30);
    req_valid[1] = 1'b0;
    wait_grants(base + 6, 60);
    req_valid = '0;
    wait_drain(40);

    // Invalid opcodes 0xF and 4 skip the datapath; opcode 3 is still valid
    set_req(1, 4'hF, 8'h33, 8'h44);
    push_g(1, -1); push_r(1, 16'h0000, 1'b1, 1);
    e0 = dp_en_total;
    req_valid = 4'b0010;
    wait_grants(n_grants + 1, 20);
    req_valid = '0;
    wait_drain(20);
    chk("invalid_no_dp", 32'(dp_en_total - e0), 32'd0);

    set_req(3, 4'd4, 8'h01, 8'h02);
    push_g(3, -1); push_r(3, 16'h0000, 1'b1, 1);
    req_valid = 4'b1000;
    wait_grants(n_grants + 1, 20);
    req_valid = '0;
    wait_drain(20);
    chk("op4_no_dp", 32'(dp_en_total - e0), 32'd0);

    set_req(0, 4'd3, 8'h70, 8'h07);
    dp_lat = 1; dp_res_val = 16'h0077;
    push_g(0, -1); push_r(0, 16'h0077, 1'b0, 2);
    req_valid = 4'b0001;
    wait_grants(n_grants + 1, 20);
    req_valid = '0;
    wait_drain(20);
    chk("op3_dp_cycles", 32'(dp_en_total - e0), 32'd1);

    // Timeout: dp_done never arrives -> 8 EXEC cycles then error
    set_req(0, 4'd1, 8'd9, 8'd3);
    dp_lat = 0; dp_res_val = 16'h1234;
    push_g(0, -1); push_r(0, 16'h0000, 1'b1, TO + 1);
    e0 = dp_en_total;
    req_valid = 4'b0001;
    wait_grants(n_grants + 1, 20);
    req_valid = '0;
    wait_drain(40);
    chk("timeout_dp_cycles", 32'(dp_en_total - e0), 32'(TO));

    // Timeout boundary: done on the 8th cycle wins
    set_req(0, 4'd2, 8'hF0, 8'h3C);
    dp_lat = TO; dp_res_val = 16'hBEEF;
    push_g(0, -1); push_r(0, 16'hBEEF, 1'b0, TO + 1);
    e0 = dp_en_total;
    req_valid = 4'b0001;
    wait_grants(n_grants + 1, 20);
    req_valid = '0;
    wait_drain(40);
    chk("boundary_dp_cycles", 32'(dp_en_total - e0), 32'(TO));

    // Reset on the 2nd EXEC cycle aborts silently; requester 0 then goes first
    set_req(2, 4'd0, 8'h11, 8'h22);
    dp_lat = 0;
    push_g(2, -1);
    req_valid = 4'b0100;
    wait_grants(n_grants + 1, 20);
    step();
    r0 = n_rsps;
    reset = 1'b1;
    req_valid = '0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    chk("abort_rsp", 32'({rsp_valid, rsp_result, rsp_error}), 32'd0);
    chk("abort_dp", 32'({dp_enable, dp_opcode, dp_a, dp_b}), 32'd0);
    step();
    chk("abort_no_rsp", 32'(n_rsps - r0), 32'd0);
    set_req(0, 4'd0, 8'h01, 8'h01);
    dp_lat = 1; dp_res_val = 16'h0101;
    push_g(0, -1); push_g(2, 3);
    push_r(0, 16'h0101, 1'b0, 2); push_r(2, 16'h0101, 1'b0, 2);
    base = n_grants;
    req_valid = 4'b0101;
    wait_grants(base + 2, 30);
    req_valid = '0;
    wait_drain(30);

    // Spurious dp_done in IDLE, then a request raised during EXEC
    r0 = n_rsps;
    e0 = dp_en_total;
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    repeat (3) step();
    chk("spurious_no_rsp", 32'(n_rsps - r0), 32'd0);
    chk("spurious_no_dp", 32'(dp_en_total - e0), 32'd0);
    set_req(3, 4'd0, 8'd1, 8'd2);
    set_req(1, 4'd3, 8'd4, 8'd5);
    dp_lat = 3; dp_res_val = 16'h0042;
    push_g(3, -1); push_g(1, 5);
    push_r(3, 16'h0042, 1'b0, 4); push_r(1, 16'h0042, 1'b0, 4);
    base = n_grants;
    req_valid = 4'b1000;
    wait_grants(base + 1, 20);
    req_valid = 4'b1010;
    step();
    req_valid = 4'b0010;
    wait_grants(base + 2, 30);
    req_valid = '0;
    wait_drain(30);

    chk("final_gq_empty", 32'(gq.size()), 32'd0);
    chk("final_rq_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
